// File: rtl/moore_counter_pkg.sv
// Shared definitions for the Moore counter family: the 2-bit state encoding
// and Moore output decodes used by moore_counter_gen.
package moore_counter_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    PAUSED   = 2'd2,
    DONE     = 2'd3
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s == COUNTING) || (s == PAUSED);
  endfunction

  function automatic logic is_done(input state_t s);
    return (s == DONE);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running clock-enable divider: one-cycle o_tick every DIV_COUNT clocks,
// first tick DIV_COUNT cycles after synchronous reset release.
module tick_gen #(
  parameter int DIV_COUNT = 3000000
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int CNT_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_COUNT - 1);

  logic [CNT_W-1:0] r_div_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div_cnt <= '0;
    end else if (r_div_cnt == LAST) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  assign o_tick = (r_div_cnt == LAST);

endmodule

// File: rtl/moore_counter_gen.sv
// Tick-paced up/down Moore counter with pause, abort and a timed DONE phase.
// Optional macro MOORE_COUNTER_AUTO_RESTART_EN: DONE restarts counting instead of idling.
module moore_counter_gen
  import moore_counter_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int MAX_COUNT  = 15,
  parameter int DIV_COUNT  = 3000000,
  parameter int DONE_TICKS = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_go,
  input  logic             i_dir,
  input  logic             i_pause,
  input  logic             i_abort,
  output logic [WIDTH-1:0] o_count,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_tick
);

  localparam int DONE_W = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;
  localparam logic [WIDTH-1:0]  MAX_VAL   = WIDTH'(MAX_COUNT);
  localparam logic [DONE_W-1:0] LAST_DONE = DONE_W'(DONE_TICKS - 1);

  logic              w_tick;
  logic              w_start;
  logic [WIDTH-1:0]  w_target;

  state_t            r_state;
  logic [WIDTH-1:0]  r_count;
  logic              r_dir_q;
  logic              r_go_pend;
  logic [DONE_W-1:0] r_done_cnt;
  logic              r_busy;
  logic              r_done;

  state_t            w_state_nxt;
  logic [WIDTH-1:0]  w_count_nxt;
  logic              w_dir_nxt;
  logic              w_go_pend_nxt;
  logic [DONE_W-1:0] w_done_cnt_nxt;

  tick_gen #(
    .DIV_COUNT(DIV_COUNT)
  ) u_tick_gen (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .o_tick(w_tick)
  );

  // A go seen between ticks is remembered so short pulses are never lost.
  assign w_start  = i_go | r_go_pend;
  assign w_target = r_dir_q ? '0 : MAX_VAL;

  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_dir_nxt      = r_dir_q;
    w_go_pend_nxt  = r_go_pend;
    w_done_cnt_nxt = r_done_cnt;

    if (i_abort) begin
      w_state_nxt   = IDLE;
      w_count_nxt   = '0;
      w_go_pend_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_count_nxt = '0;
          if (w_tick && w_start) begin
            w_state_nxt   = COUNTING;
            w_dir_nxt     = i_dir;
            w_count_nxt   = i_dir ? MAX_VAL : '0;
            w_go_pend_nxt = 1'b0;
          end else if (i_go) begin
            w_go_pend_nxt = 1'b1;
          end
        end

        // Pause outranks reaching the target, which outranks stepping.
        COUNTING: begin
          if (w_tick) begin
            if (i_pause) begin
              w_state_nxt = PAUSED;
            end else if (r_count == w_target) begin
              w_state_nxt    = DONE;
              w_done_cnt_nxt = '0;
            end else if (r_dir_q) begin
              w_count_nxt = r_count - 1'b1;
            end else begin
              w_count_nxt = r_count + 1'b1;
            end
          end
        end

        PAUSED: begin
          if (w_tick && !i_pause) begin
            w_state_nxt = COUNTING;
          end
        end

        DONE: begin
          if (w_tick) begin
            if (r_done_cnt == LAST_DONE) begin
`ifdef MOORE_COUNTER_AUTO_RESTART_EN
              w_state_nxt = COUNTING;
              w_dir_nxt   = i_dir;
              w_count_nxt = i_dir ? MAX_VAL : '0;
`else
              w_state_nxt = IDLE;
              w_count_nxt = '0;
`endif
            end else begin
              w_done_cnt_nxt = r_done_cnt + 1'b1;
            end
          end
        end

        default: begin
          w_state_nxt = IDLE;
          w_count_nxt = '0;
        end
      endcase
    end
  end

  // busy/done are registered from the next state so they track r_state exactly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_dir_q    <= 1'b0;
      r_go_pend  <= 1'b0;
      r_done_cnt <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_dir_q    <= w_dir_nxt;
      r_go_pend  <= w_go_pend_nxt;
      r_done_cnt <= w_done_cnt_nxt;
      r_busy     <= is_busy(w_state_nxt);
      r_done     <= is_done(w_state_nxt);
    end
  end

  assign o_count = r_count;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_tick  = w_tick;

endmodule

// File: tb/tb_moore_counter_gen.sv
// Directed bench for moore_counter_gen (WIDTH=4, MAX_COUNT=5, DIV_COUNT=4, DONE_TICKS=2),
// default build with MOORE_COUNTER_AUTO_RESTART_EN undefined.
module tb_moore_counter_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       go = 1'b0;
  logic       dir = 1'b0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic       tick;

  int total = 0;
  int bad = 0;
  int tbDiv = 0;

  moore_counter_gen #(
    .WIDTH(4),
    .MAX_COUNT(5),
    .DIV_COUNT(4),
    .DONE_TICKS(2)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_go   (go),
    .i_dir  (dir),
    .i_pause(pause),
    .i_abort(abort),
    .o_count(count),
    .o_busy (busy),
    .o_done (done),
    .o_tick (tick)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic g, input logic d, input logic p, input logic a);
    go    = g;
    dir   = d;
    pause = p;
    abort = a;
  endtask

  // Advance one clock (negedge to negedge) and track the expected divider phase.
  task automatic nextCycle();
    logic rstSampled;
    @(posedge clk);
    rstSampled = rst;
    @(negedge clk);
    tbDiv = rstSampled ? 0 : ((tbDiv == 3) ? 0 : tbDiv + 1);
    checkOutput("tick", tick, (tbDiv == 3));
  endtask

  // Advance through the next tick edge; afterwards the tick has been consumed.
  task automatic toTick();
    for (int guard = 0; guard < 4 && tbDiv != 3; guard++) nextCycle();
    nextCycle();
  endtask

  task automatic checkState(input string tag, input logic [3:0] expCount, input logic expBusy, input logic expDone);
    checkOutput({tag, ".count"}, count, expCount);
    checkOutput({tag, ".busy"}, busy, expBusy);
    checkOutput({tag, ".done"}, done, expDone);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset and first-tick timing
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    nextCycle();
    nextCycle();
    checkState("reset", 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    nextCycle();
    nextCycle();
    nextCycle();
    nextCycle();
    checkState("idleNoGo", 4'd0, 1'b0, 1'b0);

    // Up run from a 1-clk go pulse
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkState("upPending", 4'd0, 1'b0, 1'b0);
    toTick();
    checkState("upStart", 4'd0, 1'b1, 1'b0);
    for (int v = 1; v <= 5; v++) begin
      toTick();
      checkState("upStep", 4'(v), 1'b1, 1'b0);
    end
    toTick();
    checkState("upDone", 4'd5, 1'b0, 1'b1);
    for (int i = 1; i < 8; i++) begin
      nextCycle();
      checkOutput("upDoneHold", done, 1'b1);
    end
    nextCycle();
    checkState("upIdle", 4'd0, 1'b0, 1'b0);

    // Down run, dir toggled mid-run
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    toTick();
    checkState("downStart", 4'd5, 1'b1, 1'b0);
    for (int v = 4; v >= 0; v--) begin
      if (v == 3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      toTick();
      checkState("downStep", 4'(v), 1'b1, 1'b0);
    end
    toTick();
    checkState("downDone", 4'd0, 1'b0, 1'b1);
    toTick();
    checkState("downDone2", 4'd0, 1'b0, 1'b1);
    toTick();
    checkState("downIdle", 4'd0, 1'b0, 1'b0);

    // Pause at count 3 for 3 ticks
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) toTick();
    checkState("prePause", 4'd3, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      toTick();
      checkState("paused", 4'd3, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    toTick();
    checkState("resumeOnly", 4'd3, 1'b1, 1'b0);
    toTick();
    checkState("resumeStep", 4'd4, 1'b1, 1'b0);

    // Abort from count 4, off-tick
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkState("abort4", 4'd0, 1'b0, 1'b0);

    // Abort at count 2
    toTick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    toTick();
    toTick();
    toTick();
    checkState("preAbort2", 4'd2, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkState("abort2", 4'd0, 1'b0, 1'b0);

    // Abort together with go on a tick edge: no start, no pending go
    while (tbDiv != 3) nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkState("abortGo", 4'd0, 1'b0, 1'b0);
    toTick();
    checkState("abortGoNoPend", 4'd0, 1'b0, 1'b0);

    // Reset in the middle of DONE
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) toTick();
    checkState("preRstDone", 4'd5, 1'b0, 1'b1);
    nextCycle();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    checkState("rstMidDone", 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) nextCycle();
    checkState("postRstIdle", 4'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/moore_counter_gen.md
Name: moore_counter_gen

Overview:
Parametrised successor to the single-purpose button-driven Moore counter. Runs in a single clock domain and uses an internal clock-enable tick instead of a derived clock. Adds width/limit/divider parameters, up/down direction, pause, abort and a configurable done hold time. Sits between the board-level button conditioning (inversion/sync done outside) and the LED/status drivers.

Parameters:
WIDTH, 4, count output width.
MAX_COUNT, 15, terminal value for up count and start value for down count; 1 <= MAX_COUNT <= 2^WIDTH-1.
DIV_COUNT, 3000000, clk cycles per tick (4 Hz at 12 MHz); >= 2; divider width derived internally via $clog2.
DONE_TICKS, 1, ticks spent in DONE; >= 1.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
go  in  1  start request, active-high level or pulse (any length >= 1 clk)
dir  in  1  0 = count up 0->MAX_COUNT, 1 = count down MAX_COUNT->0; sampled only on start
pause  in  1  level; freezes counting while high
abort  in  1  active-high; returns to IDLE on next clk
count  out  WIDTH  current count value
busy  out  1  high in COUNTING or PAUSED
done  out  1  high in DONE
tick  out  1  one-clk strobe every DIV_COUNT cycles (debug/chaining)

Behaviour:
- Reset (sync, all state): state=IDLE, count=0, busy=0, done=0, div_cnt=0, go_pend=0, dir_q=0, done_cnt=0. rst overrides every other input.
- Tick divider: div_cnt counts 0..DIV_COUNT-1 and wraps; free-running in all states. tick=1 in the cycle where div_cnt==DIV_COUNT-1. First tick falls DIV_COUNT cycles after reset release.
- go_pend: set on any clk with go=1 in IDLE; cleared on leaving IDLE or on abort. Start condition = (go | go_pend) on tick.
- FSM state register is 2-bit: IDLE=0, COUNTING=1, PAUSED=2, DONE=3. Transitions occur only on tick, except abort.
- IDLE: count=0. On tick with start: -> COUNTING; dir_q<=dir; count<=dir ? MAX_COUNT : 0.
- COUNTING, on tick, in priority order:
  - pause=1 -> PAUSED, count held.
  - else if count==target (MAX_COUNT up, 0 down) -> DONE, count held at target, done_cnt<=0.
  - else count +/-1.
- PAUSED: count held. On tick with pause=0 -> COUNTING; there is no step on that tick.
- DONE: count held. done_cnt increments on each tick. On the tick where done_cnt==DONE_TICKS-1 -> IDLE, count<=0.
- abort: on any clk in any state -> IDLE next cycle, count=0, go_pend=0. Abort beats go, pause and tick in the same cycle.
- Latency:
  - start to first count step: 1 tick.
  - full run: MAX_COUNT steps + 1 terminal tick, then DONE for DONE_TICKS ticks.
  - done width = DONE_TICKS*DIV_COUNT clk cycles.
- Outputs are Moore: busy and done decode state only. count is registered. No wrap-around is possible; count never leaves 0..MAX_COUNT.
- Illegal state encodings are unreachable; the default branch goes to IDLE with count=0.
- Changes to dir while busy are ignored.

Optional Feature:
MOORE_COUNTER_AUTO_RESTART_EN
- Defined: at the end of DONE, when abort is not asserted, go directly to COUNTING; sample dir afresh and reload the start value. The block runs continuously until abort.
- Undefined: DONE always returns to IDLE and waits for a new go.

Decomposition:
- Shared package (moore_counter_pkg): state localparams IDLE/COUNTING/PAUSED/DONE and the 2-bit state width.
- Sub-module tick_gen: DIV_COUNT-parametrised divider with clk, rst and tick output. It is reused by other timed blocks.
- FSM, counter datapath and done timer stay in the top module.

Test Plan:
All cases use WIDTH=4, MAX_COUNT=5, DIV_COUNT=4, DONE_TICKS=2.
- Up run: 1-clk go pulse in IDLE -> busy=1 on next tick, count 0,1,2,3,4,5 on successive ticks, then done=1 for 8 clk, then count=0, busy=0.
- Down run: dir=1 with go -> count 5,4,3,2,1,0, then DONE; dir toggled mid-run has no effect.
- Pause: pause=1 while count=3, held 3 ticks -> count stays 3 and busy=1; after pause drops, next tick is resume only, following tick gives count=4.
- Abort: abort during COUNTING at count=2 -> next clk count=0, busy=0; abort plus go in same cycle -> stays IDLE with go_pend=0.
- Reset mid-DONE: rst for 1 clk -> all outputs 0 next clk; first tick exactly 4 clk after release.
- With MOORE_COUNTER_AUTO_RESTART_EN: after DONE (2 ticks) -> count restarts at 0 without go; repeats until abort.
